layer_register_bank: RTL

LAYER_REGISTER_BANK -- requirements
Module: layer_register_bank

---
 rtl/layer_regs_pkg.sv | 19 +
 rtl/layer_register_bank_if.sv | 46 ++++
 rtl/layer_bank_ram.sv | 44 ++++
 rtl/layer_register_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_regs_pkg.sv
// Shared types and width helpers for the layer register bank.
// Optional shadow/active double buffering is enabled by LAYER_REGS_SHADOW_EN.
package layer_regs_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StClear  = 2'd1,
        StCommit = 2'd2
    } state_e;

    function automatic int unsigned calc_layer_w(input int unsigned num_layers);
        return (num_layers > 1) ? int'($clog2(num_layers)) : 1;
    endfunction

    function automatic int unsigned calc_reg_idx_w(input int unsigned num_regs);
        return (num_regs > 1) ? int'($clog2(num_regs)) : 1;
    endfunction

endpackage

// File: rtl/layer_register_bank_if.sv
// Controller, clear/commit and pipeline signal bundle of the layer register bank.
// The bank drives through the slave modport; the controller/pipeline side uses master.
interface layer_register_bank_if #(
    parameter int unsigned NUM_LAYERS = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned REG_W      = 16
);
    import layer_regs_pkg::*;

    localparam int unsigned LAYER_W   = calc_layer_w(NUM_LAYERS);
    localparam int unsigned REG_IDX_W = calc_reg_idx_w(NUM_REGS);

    logic [LAYER_W-1:0]          ctrl_layer;
    logic [REG_IDX_W-1:0]        ctrl_reg;
    logic                        ctrl_wr_en;
    logic [REG_W-1:0]            ctrl_wr_data;
    logic                        ctrl_rd_en;
    logic [REG_W-1:0]            ctrl_rd_data;
    logic                        ctrl_rd_valid;
    logic                        ctrl_wr_drop;
    logic                        clr_req;
    logic [LAYER_W-1:0]          clr_layer;
    logic                        clr_all;
    logic                        clr_ack;
    logic                        commit;
    logic                        busy;
    logic [LAYER_W-1:0]          pipe_layer;
    logic                        pipe_rd_en;
    logic [NUM_REGS*REG_W-1:0]   pipe_regs;
    logic                        pipe_valid;

    modport master (
        output ctrl_layer, ctrl_reg, ctrl_wr_en, ctrl_wr_data, ctrl_rd_en,
        output clr_req, clr_layer, clr_all, commit, pipe_layer, pipe_rd_en,
        input  ctrl_rd_data, ctrl_rd_valid, ctrl_wr_drop, clr_ack, busy,
        input  pipe_regs, pipe_valid
    );

    modport slave (
        input  ctrl_layer, ctrl_reg, ctrl_wr_en, ctrl_wr_data, ctrl_rd_en,
        input  clr_req, clr_layer, clr_all, commit, pipe_layer, pipe_rd_en,
        output ctrl_rd_data, ctrl_rd_valid, ctrl_wr_drop, clr_ack, busy,
        output pipe_regs, pipe_valid
    );

endinterface

// File: rtl/layer_bank_ram.sv
// One register bank: NUM_LAYERS rows of NUM_REGS registers, per-register write
// enables into a single row and two asynchronous full-row read ports.
module layer_bank_ram
    import layer_regs_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned REG_W      = 16,
    parameter int unsigned LAYER_W    = calc_layer_w(NUM_LAYERS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LAYER_W-1:0]        wr_layer,
    input  logic [NUM_REGS-1:0]       wr_en,
    input  logic [NUM_REGS*REG_W-1:0] wr_data,
    input  logic [LAYER_W-1:0]        rd_a_layer,
    output logic [NUM_REGS*REG_W-1:0] rd_a_data,
    input  logic [LAYER_W-1:0]        rd_b_layer,
    output logic [NUM_REGS*REG_W-1:0] rd_b_data
);

    logic [NUM_REGS-1:0][REG_W-1:0] mem_q [NUM_LAYERS];
    logic [NUM_REGS-1:0][REG_W-1:0] wr_row;

    assign wr_row = wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                mem_q[l] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en[k]) begin
                    mem_q[wr_layer][k] <= wr_row[k];
                end
            end
        end
    end

    assign rd_a_data = mem_q[rd_a_layer];
    assign rd_b_data = mem_q[rd_b_layer];

endmodule

// File: rtl/layer_register_bank.sv
// Per-layer register bank with controller/pipeline ports and a clear/commit scanner.
// Define LAYER_REGS_SHADOW_EN for a shadow bank committed to the active bank on frame pulses.
module layer_register_bank
    import layer_regs_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned REG_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    layer_register_bank_if.slave bus
);

    localparam int unsigned LAYER_W = calc_layer_w(NUM_LAYERS);
    localparam int unsigned ROW_W   = NUM_REGS * REG_W;
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] scan_q, scan_d;
    logic               clr_all_q, clr_all_d;
    logic               clr_ack_q, clr_ack_d;
    logic               wr_accept;

    logic               ctrl_rd_valid_q, ctrl_wr_drop_q, pipe_valid_q;
    logic [REG_W-1:0]   ctrl_rd_data_q;
    logic [ROW_W-1:0]   pipe_regs_q;

    logic [NUM_REGS-1:0]            reg_onehot;
    logic [ROW_W-1:0]               wr_row;
    logic [ROW_W-1:0]               act_pipe_row, act_b_row;
    logic [NUM_REGS-1:0][REG_W-1:0] ctrl_row;

    logic [LAYER_W-1:0]  act_wr_layer;
    logic [NUM_REGS-1:0] act_wr_en;
    logic [ROW_W-1:0]    act_wr_data;

    assign reg_onehot = NUM_REGS'(1) << bus.ctrl_reg;
    assign wr_row     = {NUM_REGS{bus.ctrl_wr_data}};

`ifdef LAYER_REGS_SHADOW_EN
    logic [NUM_LAYERS-1:0] dirty_q, dirty_d;
    logic                  commit_pending_q, commit_pending_d;
    logic [LAYER_W-1:0]    sh_wr_layer;
    logic [NUM_REGS-1:0]   sh_wr_en;
    logic [ROW_W-1:0]      sh_wr_data;
    logic [ROW_W-1:0]      sh_ctrl_row, sh_scan_row;
    logic                  unused_act_b;

    assign unused_act_b = ^act_b_row;
    assign ctrl_row     = sh_ctrl_row;
`else
    logic unused_commit;

    assign unused_commit = bus.commit;
    assign ctrl_row      = act_b_row;
`endif

    // Next-state logic; a clear always wins over a commit in the same IDLE cycle.
    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        clr_all_d = clr_all_q;
        clr_ack_d = 1'b0;
        wr_accept = 1'b0;
`ifdef LAYER_REGS_SHADOW_EN
        dirty_d          = dirty_q;
        commit_pending_d = commit_pending_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d   = StClear;
                    clr_all_d = bus.clr_all;
                    scan_d    = bus.clr_all ? '0 : bus.clr_layer;
`ifdef LAYER_REGS_SHADOW_EN
                    if (bus.commit) commit_pending_d = 1'b1;
                end else if (bus.commit || commit_pending_q) begin
                    state_d          = StCommit;
                    scan_d           = '0;
                    commit_pending_d = 1'b0;
`endif
                end else begin
                    wr_accept = bus.ctrl_wr_en;
                end
            end
            StClear: begin
`ifdef LAYER_REGS_SHADOW_EN
                dirty_d[scan_q] = 1'b0;
                if (bus.commit) commit_pending_d = 1'b1;
`endif
                if (!clr_all_q || scan_q == LAST_LAYER) begin
                    state_d   = StIdle;
                    clr_ack_d = 1'b1;
                    scan_d    = '0;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            StCommit: begin
`ifdef LAYER_REGS_SHADOW_EN
                dirty_d[scan_q] = 1'b0;
                if (bus.commit) commit_pending_d = 1'b1;
                if (scan_q == LAST_LAYER) state_d = StIdle;
                // Power-of-two layer count: the counter wraps to 0 on the last layer.
                scan_d = scan_q + 1'b1;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
`ifdef LAYER_REGS_SHADOW_EN
        if (wr_accept) dirty_d[bus.ctrl_layer] = 1'b1;
`endif
    end

    // Bank write-port steering for controller writes, clears and commits.
    always_comb begin
        act_wr_layer = scan_q;
        act_wr_en    = '0;
        act_wr_data  = '0;
`ifdef LAYER_REGS_SHADOW_EN
        sh_wr_layer = bus.ctrl_layer;
        sh_wr_en    = '0;
        sh_wr_data  = wr_row;
        if (state_q == StClear) begin
            sh_wr_layer = scan_q;
            sh_wr_en    = '1;
            sh_wr_data  = '0;
            act_wr_en   = '1;
        end else if (state_q == StCommit) begin
            act_wr_en   = {NUM_REGS{dirty_q[scan_q]}};
            act_wr_data = sh_scan_row;
        end else if (wr_accept) begin
            sh_wr_en = reg_onehot;
        end
`else
        if (state_q == StClear) begin
            act_wr_en = '1;
        end else if (wr_accept) begin
            act_wr_layer = bus.ctrl_layer;
            act_wr_en    = reg_onehot;
            act_wr_data  = wr_row;
        end
`endif
    end

`ifdef LAYER_REGS_SHADOW_EN
    layer_bank_ram #(
        .NUM_LAYERS (NUM_LAYERS),
        .NUM_REGS   (NUM_REGS),
        .REG_W      (REG_W),
        .LAYER_W    (LAYER_W)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .wr_layer   (sh_wr_layer),
        .wr_en      (sh_wr_en),
        .wr_data    (sh_wr_data),
        .rd_a_layer (bus.ctrl_layer),
        .rd_a_data  (sh_ctrl_row),
        .rd_b_layer (scan_q),
        .rd_b_data  (sh_scan_row)
    );
`endif

    layer_bank_ram #(
        .NUM_LAYERS (NUM_LAYERS),
        .NUM_REGS   (NUM_REGS),
        .REG_W      (REG_W),
        .LAYER_W    (LAYER_W)
    ) u_active (
        .clk        (clk),
        .rst        (rst),
        .wr_layer   (act_wr_layer),
        .wr_en      (act_wr_en),
        .wr_data    (act_wr_data),
        .rd_a_layer (bus.pipe_layer),
        .rd_a_data  (act_pipe_row),
        .rd_b_layer (bus.ctrl_layer),
        .rd_b_data  (act_b_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            scan_q    <= '0;
            clr_all_q <= 1'b0;
            clr_ack_q <= 1'b0;
`ifdef LAYER_REGS_SHADOW_EN
            dirty_q          <= '0;
            commit_pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            clr_all_q <= clr_all_d;
            clr_ack_q <= clr_ack_d;
`ifdef LAYER_REGS_SHADOW_EN
            dirty_q          <= dirty_d;
            commit_pending_q <= commit_pending_d;
`endif
        end
    end

    // Read data sampled before any same-edge write, so write-then-read returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_rd_data_q  <= '0;
            ctrl_rd_valid_q <= 1'b0;
            ctrl_wr_drop_q  <= 1'b0;
            pipe_regs_q     <= '0;
            pipe_valid_q    <= 1'b0;
        end else begin
            ctrl_rd_valid_q <= bus.ctrl_rd_en;
            ctrl_wr_drop_q  <= bus.ctrl_wr_en && !wr_accept;
            pipe_valid_q    <= bus.pipe_rd_en;
            if (bus.ctrl_rd_en) ctrl_rd_data_q <= ctrl_row[bus.ctrl_reg];
            if (bus.pipe_rd_en) pipe_regs_q <= act_pipe_row;
        end
    end

    assign bus.ctrl_rd_data  = ctrl_rd_data_q;
    assign bus.ctrl_rd_valid = ctrl_rd_valid_q;
    assign bus.ctrl_wr_drop  = ctrl_wr_drop_q;
    assign bus.clr_ack       = clr_ack_q;
    assign bus.pipe_regs     = pipe_regs_q;
    assign bus.pipe_valid    = pipe_valid_q;
    assign bus.busy          = (state_q != StIdle);

endmodule
